// File: rtl/intt_loader_pkg.sv
// intt_loader_pkg: shared FSM state, lane constants and bit-reverse width helper for the DP1 loader
package intt_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, KICK, WAIT_DONE} state_t;

    localparam int COEFF_BITS_DEF = 35;
    localparam int LANES = 2;

    function automatic int rev_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/intt_loader_addr_gen.sv
// intt_loader_addr_gen: DP1 word counter with last/full flags; INTT_LOADER_BITREV_EN selects bit-reversed addressing
module intt_loader_addr_gen
    import intt_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  full
);

    localparam int RW = rev_width(DEPTH_WORDS);
    localparam int CW = RW + 1;

    logic [CW-1:0] cnt;
    logic [RW-1:0] idx;

    // word counter: clear wins over increment, never wraps past DEPTH_WORDS
    always_ff @(posedge clock) begin
        if (reset || clr) cnt <= '0;
        else if (inc) cnt <= cnt + CW'(1);
    end

    // address index: natural order, or bit-reversed over the low RW bits
    always_comb begin
        idx = '0;
`ifdef INTT_LOADER_BITREV_EN
        for (int i = 0; i < RW; i++) idx[i] = cnt[RW-1-i];
`else
        idx = cnt[RW-1:0];
`endif
    end

    assign addr = ADDR_WIDTH'(idx);
    assign last = cnt == CW'(DEPTH_WORDS - 1);
    assign full = cnt[CW-1];

endmodule

// File: rtl/intt_dp1_loader.sv
// intt_dp1_loader: packs coefficient pairs into DP1 words, kicks INTT, waits for done; INTT_LOADER_BITREV_EN enables bit-reversed write addresses
module intt_dp1_loader
    import intt_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = 39,
    parameter int ADDR_WIDTH  = 12,
    parameter int COEFF_BITS  = COEFF_BITS_DEF,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_i_load_start,
    input  logic                        io_i_abort,
    input  logic [11:0]                 io_i_coeff_index,
    input  logic                        io_i_s_valid,
    output logic                        io_o_s_ready,
    input  logic [COEFF_BITS-1:0]       io_i_s_data,
    output logic                        io_o_dp1_wren,
    output logic [ADDR_WIDTH-1:0]       io_o_dp1_wraddr,
    output logic [LANES*DATA_WIDTH-1:0] io_o_dp1_wrdata,
    output logic [11:0]                 io_o_coeff_index,
    output logic                        io_o_intt_start,
    input  logic                        io_i_intt_done,
    output logic                        io_o_frame_done,
    output logic                        io_o_busy
);

    state_t state, state_n;
    logic half, hs, wr, clr, last, full;
    logic [COEFF_BITS-1:0] pack;
    logic [ADDR_WIDTH-1:0] addr;

    assign hs  = io_i_s_valid && io_o_s_ready;
    assign wr  = hs && half && !io_i_abort;
    assign clr = state_n == IDLE;

    intt_loader_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_addr_gen (
        .clock(clock),
        .reset(reset),
        .clr  (clr),
        .inc  (wr),
        .addr (addr),
        .last (last),
        .full (full)
    );

    // next state; abort overrides every transition
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = io_i_load_start ? LOAD : IDLE;
            LOAD:      state_n = (io_o_dp1_wren && full) ? KICK : LOAD;
            KICK:      state_n = WAIT_DONE;
            WAIT_DONE: state_n = io_i_intt_done ? IDLE : WAIT_DONE;
            default:   state_n = IDLE;
        endcase
        if (io_i_abort) state_n = IDLE;
    end

    // state, pack register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            half             <= 1'b0;
            pack             <= '0;
            io_o_s_ready     <= 1'b0;
            io_o_dp1_wren    <= 1'b0;
            io_o_dp1_wraddr  <= '0;
            io_o_dp1_wrdata  <= '0;
            io_o_coeff_index <= '0;
            io_o_intt_start  <= 1'b0;
            io_o_frame_done  <= 1'b0;
            io_o_busy        <= 1'b0;
        end else begin
            state           <= state_n;
            io_o_s_ready    <= state_n == LOAD && !full && !(wr && last);
            io_o_dp1_wren   <= wr;
            io_o_intt_start <= state_n == KICK;
            io_o_frame_done <= state == WAIT_DONE && io_i_intt_done && !io_i_abort;
            io_o_busy       <= state_n != IDLE;
            if (state == IDLE && state_n == LOAD) io_o_coeff_index <= io_i_coeff_index;
            if (wr) begin
                io_o_dp1_wraddr <= addr;
                io_o_dp1_wrdata <= {DATA_WIDTH'(io_i_s_data), DATA_WIDTH'(pack)};
            end
            if (hs && !half) pack <= io_i_s_data;
            half <= clr ? 1'b0 : hs ? !half : half;
        end
    end

endmodule

// File: tb/tb_intt_dp1_loader.sv
// tb_intt_dp1_loader: directed/randomized bench with a pair-packing reference model for intt_dp1_loader
module tb_intt_dp1_loader;

    localparam int DW = 39;
    localparam int AW = 12;
    localparam int CB = 35;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic io_i_load_start = 1'b0;
    logic io_i_abort = 1'b0;
    logic [11:0] io_i_coeff_index = '0;
    logic io_i_s_valid = 1'b0;
    logic [CB-1:0] io_i_s_data = '0;
    logic io_i_intt_done = 1'b0;
    logic io_o_s_ready, io_o_dp1_wren, io_o_intt_start, io_o_frame_done, io_o_busy;
    logic [AW-1:0] io_o_dp1_wraddr;
    logic [2*DW-1:0] io_o_dp1_wrdata;
    logic [11:0] io_o_coeff_index;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int start_cyc = 0;
    int consec = 0;
    logic prev_wren = 1'b0;
    logic [AW-1:0] wa[$];
    logic [2*DW-1:0] wd[$];
    int wc[$];
    logic [CB-1:0] co[8];

    intt_dp1_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .COEFF_BITS (CB),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_i_load_start (io_i_load_start),
        .io_i_abort      (io_i_abort),
        .io_i_coeff_index(io_i_coeff_index),
        .io_i_s_valid    (io_i_s_valid),
        .io_o_s_ready    (io_o_s_ready),
        .io_i_s_data     (io_i_s_data),
        .io_o_dp1_wren   (io_o_dp1_wren),
        .io_o_dp1_wraddr (io_o_dp1_wraddr),
        .io_o_dp1_wrdata (io_o_dp1_wrdata),
        .io_o_coeff_index(io_o_coeff_index),
        .io_o_intt_start (io_o_intt_start),
        .io_i_intt_done  (io_i_intt_done),
        .io_o_frame_done (io_o_frame_done),
        .io_o_busy       (io_o_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (io_o_dp1_wren === 1'b1) begin
            wa.push_back(io_o_dp1_wraddr);
            wd.push_back(io_o_dp1_wrdata);
            wc.push_back(cyc);
            if (prev_wren) consec++;
        end
        prev_wren = io_o_dp1_wren === 1'b1;
        if (io_o_intt_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
        end
        if (io_o_frame_done === 1'b1) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int w);
`ifdef INTT_LOADER_BITREV_EN
        return AW'((w % 2) * 2 + (w / 2));
`else
        return AW'(w);
`endif
    endfunction

    function automatic logic [2*DW-1:0] exp_word(input logic [CB-1:0] ev, input logic [CB-1:0] od);
        logic [2*DW-1:0] hi, lo;
        hi = od;
        lo = ev;
        return (hi << DW) | lo;
    endfunction

    function automatic logic [CB-1:0] rnd_coeff();
        return CB'({$urandom, $urandom});
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, io_o_s_ready, 0);
        chk({tag, "_wren"}, io_o_dp1_wren, 0);
        chk({tag, "_wraddr"}, io_o_dp1_wraddr, 0);
        chk({tag, "_wrdata"}, io_o_dp1_wrdata, 0);
        chk({tag, "_index"}, io_o_coeff_index, 0);
        chk({tag, "_start"}, io_o_intt_start, 0);
        chk({tag, "_fdone"}, io_o_frame_done, 0);
        chk({tag, "_busy"}, io_o_busy, 0);
    endtask

    task automatic send(input logic [CB-1:0] d);
        logic r;
        int n;
        n = 0;
        io_i_s_valid = 1'b1;
        io_i_s_data = d;
        do begin
            r = io_o_s_ready;
            tick();
            n++;
        end while (!r && n < 100);
        io_i_s_valid = 1'b0;
        io_i_s_data = rnd_coeff();
        chk("send_handshake", r, 1);
    endtask

    task automatic start_frame(input logic [11:0] idx);
        io_i_load_start = 1'b1;
        io_i_coeff_index = idx;
        tick();
        io_i_load_start = 1'b0;
        io_i_coeff_index = 12'($urandom);
    endtask

    task automatic run_frame(input logic [11:0] idx, input int mode, input int wait_n, input bit finish);
        int b, s0, d0, c0, bad;
        logic seen;
        b = wa.size();
        s0 = n_start;
        d0 = n_done;
        c0 = consec;
        start_frame(idx);
        chk("busy_after_start", io_o_busy, 1);
        chk("ready_in_load", io_o_s_ready, 1);
        chk("index_latched", io_o_coeff_index, idx);
        for (int i = 0; i < 8; i++) begin
            if (mode == 1 && i == 1) gap(20);
            else if (mode == 1 && i == 3) begin
                io_i_load_start = 1'b1;
                io_i_coeff_index = 12'h123;
                tick();
                io_i_load_start = 1'b0;
            end else if (mode != 0) gap($urandom_range(0, 3));
            send(co[i]);
        end
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (io_o_intt_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("intt_start_seen", seen, 1);
        chk("ready_after_last", io_o_s_ready, 0);
        tick();
        chk("intt_start_one_cycle", io_o_intt_start, 0);
        chk("busy_in_wait", io_o_busy, 1);
        chk("n_writes", wa.size() - b, DEPTH);
        for (int w = 0; w < DEPTH; w++) begin
            chk($sformatf("wraddr%0d", w), wa[b+w], exp_addr(w));
            chk($sformatf("wrdata%0d", w), wd[b+w], exp_word(co[2*w], co[2*w+1]));
            if (w > 0 && mode == 0) chk($sformatf("spacing%0d", w), wc[b+w] - wc[b+w-1], 2);
        end
        chk("start_after_last_write", start_cyc - wc[b+DEPTH-1], 1);
        chk("no_back_to_back_wren", consec - c0, 0);
        if (!finish) begin
            reset = 1'b1;
            tick();
            chk_zero("reset_in_wait");
            reset = 1'b0;
            tick();
            chk("no_fdone_after_reset", n_done - d0, 0);
        end else begin
            bad = 0;
            repeat (wait_n) begin
                tick();
                if (io_o_busy !== 1'b1 || io_o_frame_done !== 1'b0) bad++;
            end
            chk("busy_during_wait", bad, 0);
            io_i_intt_done = 1'b1;
            tick();
            io_i_intt_done = 1'b0;
            chk("frame_done_pulse", io_o_frame_done, 1);
            chk("busy_after_done", io_o_busy, 0);
            chk("index_at_done", io_o_coeff_index, idx);
            tick();
            chk("frame_done_one_cycle", io_o_frame_done, 0);
            chk("n_intt_start", n_start - s0, 1);
            chk("n_frame_done", n_done - d0, 1);
        end
    endtask

    initial begin
        int b, s0, d0;
        logic [2*DW-1:0] t;

        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) co[i] = CB'(i + 1);
        run_frame(12'h005, 0, 50, 1'b1);

        run_frame(12'h005, 1, 8, 1'b1);

        for (int i = 0; i < 8; i++) co[i] = rnd_coeff();
        run_frame(12'($urandom), 2, $urandom_range(1, 10), 1'b1);

        for (int i = 0; i < 8; i++) co[i] = {CB{1'b1}};
        run_frame(12'hFFF, 0, 3, 1'b1);
        t = wd[wd.size()-1];
        chk("lane0_pad_zero", t[DW-1:CB], 0);
        chk("lane1_pad_zero", t[2*DW-1:DW+CB], 0);

        for (int i = 0; i < 8; i++) co[i] = rnd_coeff();
        b = wa.size();
        s0 = n_start;
        d0 = n_done;
        start_frame(12'h0AA);
        for (int i = 0; i < 5; i++) send(co[i]);
        chk("ready_before_abort", io_o_s_ready, 1);
        io_i_abort = 1'b1;
        io_i_s_valid = 1'b1;
        io_i_s_data = co[5];
        tick();
        io_i_abort = 1'b0;
        io_i_s_valid = 1'b0;
        chk("abort_busy", io_o_busy, 0);
        chk("abort_ready", io_o_s_ready, 0);
        chk("abort_wren", io_o_dp1_wren, 0);
        gap(4);
        chk("abort_n_writes", wa.size() - b, 2);
        chk("abort_word1", wd[b+1], exp_word(co[2], co[3]));
        chk("abort_no_start", n_start - s0, 0);
        chk("abort_no_fdone", n_done - d0, 0);

        for (int i = 0; i < 8; i++) co[i] = rnd_coeff();
        run_frame(12'($urandom), 2, 5, 1'b1);

        io_i_load_start = 1'b1;
        io_i_abort = 1'b1;
        io_i_coeff_index = 12'h03C;
        tick();
        io_i_load_start = 1'b0;
        io_i_abort = 1'b0;
        chk("abort_beats_start_busy", io_o_busy, 0);
        chk("abort_beats_start_ready", io_o_s_ready, 0);

        d0 = n_done;
        s0 = n_start;
        io_i_intt_done = 1'b1;
        gap(3);
        io_i_intt_done = 1'b0;
        tick();
        chk("idle_done_busy", io_o_busy, 0);
        chk("idle_done_no_fdone", n_done - d0, 0);
        chk("idle_done_no_start", n_start - s0, 0);

        for (int i = 0; i < 8; i++) co[i] = rnd_coeff();
        run_frame(12'h321, 2, 0, 1'b0);

        for (int i = 0; i < 8; i++) co[i] = rnd_coeff();
        run_frame(12'h7E1, 0, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intt_dp1_loader.md
Name: intt_dp1_loader

Overview:
- Upstream feeder for the preprocess/INTT stage.
- Accepts a valid/ready stream of 35-bit polynomial coefficients and packs two coefficients per DP1 word.
- Drives the DP1 write port (wren/wraddr/wrdata) for one full polynomial, then issues a one-cycle INTT start and waits for INTT done.
- Reports frame completion upstream and supplies the coefficient index the downstream stage consumes.

Parameters:
- DATA_WIDTH, 39: lane width of a DP1 word; each word carries 2 lanes.
- ADDR_WIDTH, 12: DP1 address width.
- COEFF_BITS, 35: significant bits per coefficient; must be ≤ DATA_WIDTH.
- DEPTH_WORDS, 2048: DP1 words per polynomial; must be a power of two and ≤ 2^ADDR_WIDTH.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- io_i_load_start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- io_i_abort  in  1  return to IDLE from any state.
- io_i_coeff_index  in  12  frame index; latched on an accepted load_start.
- io_i_s_valid  in  1  coefficient stream valid.
- io_o_s_ready  out  1  coefficient stream ready.
- io_i_s_data  in  COEFF_BITS  coefficient.
- io_o_dp1_wren  out  1  DP1 write enable.
- io_o_dp1_wraddr  out  ADDR_WIDTH  DP1 write address.
- io_o_dp1_wrdata  out  2*DATA_WIDTH  packed word; lane0 = even coefficient, lane1 = odd coefficient; each lane zero-extended from COEFF_BITS.
- io_o_coeff_index  out  12  latched frame index; stable from load_start through frame_done.
- io_o_intt_start  out  1  one-cycle INTT kick.
- io_i_intt_done  in  1  INTT completion, level or pulse.
- io_o_frame_done  out  1  one-cycle completion pulse.
- io_o_busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset drives every output to 0 and the FSM to IDLE; the half-word flag, word counter and pack register clear.
- FSM states: IDLE, LOAD, KICK, WAIT_DONE.
  - IDLE -> LOAD on load_start. Latch coeff_index, clear counters.
  - LOAD -> KICK on the cycle the final word's wren is asserted.
  - KICK -> WAIT_DONE unconditionally. intt_start = 1 for exactly this one cycle.
  - WAIT_DONE -> IDLE when intt_done = 1. frame_done pulses on the following cycle.
- s_ready = 1 only in LOAD, and only while the word counter < DEPTH_WORDS. Any handshake outside LOAD is impossible; s_valid there is ignored.
- Packing:
  - The first accepted coefficient of a pair is held in the pack register.
  - Acceptance of the second coefficient produces wren = 1 on the next cycle, with wrdata = {zext(odd), zext(even)} and wraddr = word counter. The counter then increments.
  - Latency: second-coefficient handshake to wren is 1 cycle.
  - Back-to-back valid gives one write every 2 cycles; wren is never asserted on consecutive cycles.
- Stalls: s_valid low holds all state. The half-word flag persists indefinitely.
- Word counter width is log2(DEPTH_WORDS)+1. Unused high address bits are driven to 0. There is no wrap; s_ready drops after the final write.
- abort:
  - In any state, the next cycle is IDLE with counters cleared and wren = 0.
  - No intt_start or frame_done is issued.
  - A write whose handshake occurred on the abort cycle is discarded.
  - abort and load_start on the same cycle: abort wins and the FSM stays IDLE.
- load_start while busy is ignored; coeff_index is not relatched.
- intt_done seen outside WAIT_DONE is ignored.
- Reset mid-frame behaves like abort; no pulses are emitted.

Optional Feature:
- Macro INTT_LOADER_BITREV_EN.
- Defined: wraddr = bit-reverse of the word counter over its low log2(DEPTH_WORDS) bits; the natural-order stream lands in bit-reversed DP1 order.
- Undefined: wraddr = word counter (natural order).
- Timing and FSM are identical in both builds.

Decomposition:
- Package intt_loader_pkg:
  - FSM state enum.
  - Localparams for COEFF_BITS default and lane count (2).
  - Function for bit-reverse width, log2(DEPTH_WORDS).
- One sub-module, intt_loader_addr_gen: word counter, clear/increment, last-word flag, optional bit-reversal. The top holds the FSM, pack register and output registers.

Test Plan (bench uses DEPTH_WORDS=4, COEFF_BITS=35, DATA_WIDTH=39):
- load_start with index 0x005, then 8 back-to-back coefficients 1..8 -> writes addr0..3 with lanes (1,2),(3,4),(5,6),(7,8) spaced every 2 cycles; intt_start 1 cycle after addr3 write; coeff_index = 0x005 throughout.
- intt_done held 0 for 50 cycles then pulsed -> busy stays high during the wait; frame_done pulses exactly 1 cycle after intt_done; busy = 0 on the next cycle.
- Random s_valid gaps including a 20-cycle stall between the even and odd coefficient -> identical write data/addresses to scenario 1; no spurious wren.
- abort asserted after 5 coefficients accepted -> IDLE next cycle, no intt_start or frame_done; a new frame then writes addr0 with lanes (new1,new2).
- Coefficient 0x7_FFFF_FFFF (all 35 bits) -> lane bits [38:35] = 0. With INTT_LOADER_BITREV_EN, write addresses are 0,2,1,3.
- load_start during LOAD, and intt_done during IDLE -> both ignored, no state change; reset asserted in WAIT_DONE -> all outputs 0 on the next cycle.
